// File: rtl/acc_readout_if.sv
// ---------------------------------------------------------------------------
// acc_readout_if
// Valid/ready word stream carrying an accumulator result to its sink.
//   dout       : data word (driven by the master)
//   dout_valid : dout holds a valid beat (master)
//   dout_last  : current beat is the final beat of the result (master)
//   dout_ready : sink accepts the beat (slave)
// ---------------------------------------------------------------------------
interface acc_readout_if #(
    parameter int WORD_W = 16
);
    logic [WORD_W-1:0] dout;
    logic              dout_valid;
    logic              dout_ready;
    logic              dout_last;

    modport master (
        output dout,
        output dout_valid,
        output dout_last,
        input  dout_ready
    );

    modport slave (
        input  dout,
        input  dout_valid,
        input  dout_last,
        output dout_ready
    );
endinterface

// File: rtl/acc_readout.sv
// ---------------------------------------------------------------------------
// acc_readout
// Captures the accumulator result on acc_done, pulses acc_clr once, and
// streams the result as three 16-bit beats (LSW first, top beat
// sign-extended) over a valid/ready interface.
// Ports:
//   clk         : clock, rising edge
//   clr_n       : asynchronous active-low reset
//   acc_in      : accumulator value, sampled when acc_done is high
//   acc_done    : one-cycle completion strobe
//   acc_clr     : one-cycle clear pulse to the accumulator
//   dout_bus    : output stream (dout, dout_valid, dout_last, dout_ready)
//   busy        : a captured result is still being drained
//   overrun     : sticky, an acc_done strobe was dropped
//   overrun_clr : synchronous clear of overrun (a simultaneous set wins)
// All outputs come straight from flops.
// ---------------------------------------------------------------------------
module acc_readout #(
    parameter int ACC_W  = 35,
    parameter int WORD_W = 16
) (
    input  logic                 clk,
    input  logic                 clr_n,
    input  logic [ACC_W-1:0]     acc_in,
    input  logic                 acc_done,
    output logic                 acc_clr,
    acc_readout_if.master        dout_bus,
    output logic                 busy,
    output logic                 overrun,
    input  logic                 overrun_clr
);
    // Bits left over for the top beat once two full words are taken.
    localparam int TOP_W = ACC_W - 2 * WORD_W;

    logic [ACC_W-1:0]  cap_r;
    logic              active_r;
    logic [1:0]        beat_r;

    logic [ACC_W-1:0]  cap_s;
    logic              active_s;
    logic [1:0]        beat_s;
    logic [WORD_W-1:0] dout_s;
    logic              last_s;
    logic              clr_s;
    logic              overrun_s;
    logic              hs_s;
    logic              accept_s;

    // Word presented for a given beat; the top beat is sign-extended.
    function automatic logic [WORD_W-1:0] beat_word(input logic [ACC_W-1:0] cap,
                                                   input logic [1:0]       beat);
        logic [WORD_W-1:0] w;
        case (beat)
            2'd0:    w = cap[WORD_W-1:0];
            2'd1:    w = cap[2*WORD_W-1:WORD_W];
            2'd2:    w = {{(WORD_W-TOP_W){cap[ACC_W-1]}}, cap[ACC_W-1:2*WORD_W]};
            default: w = {WORD_W{1'b0}};
        endcase
        return w;
    endfunction

    // Next-state: capture/advance decisions and next registered outputs.
    always_comb begin
        cap_s     = cap_r;
        active_s  = active_r;
        beat_s    = beat_r;
        clr_s     = 1'b0;
        overrun_s = overrun;

        hs_s = dout_bus.dout_valid & dout_bus.dout_ready;
        // Idle, or the last beat leaves this very cycle.
        accept_s = ~active_r | (hs_s & (beat_r == 2'd2));

        if (acc_done && accept_s) begin
            cap_s    = acc_in;
            active_s = 1'b1;
            beat_s   = 2'd0;
            clr_s    = 1'b1;
        end else if (hs_s) begin
            if (beat_r == 2'd2) begin
                active_s = 1'b0;
                beat_s   = 2'd0;
            end else begin
                beat_s = beat_r + 2'd1;
            end
        end else begin
            active_s = active_r;
        end

        if (acc_done && !accept_s) begin
            overrun_s = 1'b1;
        end else if (overrun_clr) begin
            overrun_s = 1'b0;
        end else begin
            overrun_s = overrun;
        end

        if (active_s) begin
            dout_s = beat_word(cap_s, beat_s);
            last_s = (beat_s == 2'd2);
        end else begin
            dout_s = {WORD_W{1'b0}};
            last_s = 1'b0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            cap_r               <= {ACC_W{1'b0}};
            active_r            <= 1'b0;
            beat_r              <= 2'd0;
            acc_clr             <= 1'b0;
            overrun             <= 1'b0;
            busy                <= 1'b0;
            dout_bus.dout       <= {WORD_W{1'b0}};
            dout_bus.dout_valid <= 1'b0;
            dout_bus.dout_last  <= 1'b0;
        end else begin
            cap_r               <= cap_s;
            active_r            <= active_s;
            beat_r              <= beat_s;
            acc_clr             <= clr_s;
            overrun             <= overrun_s;
            busy                <= active_s;
            dout_bus.dout       <= dout_s;
            dout_bus.dout_valid <= active_s;
            dout_bus.dout_last  <= last_s;
        end
    end
endmodule

// File: tb/tb_acc_readout.sv
// ---------------------------------------------------------------------------
// tb_acc_readout
// Directed scenarios followed by randomized traffic, checked against a
// queue-of-pending-words reference model.
// ---------------------------------------------------------------------------
module tb_acc_readout;
    logic        clk = 1'b0;
    logic        clr_n;
    logic [34:0] acc_in;
    logic        acc_done;
    logic        overrun_clr;
    logic        acc_clr;
    logic        busy;
    logic        overrun;

    acc_readout_if #(.WORD_W(16)) bus ();

    acc_readout dut (
        .clk         (clk),
        .clr_n       (clr_n),
        .acc_in      (acc_in),
        .acc_done    (acc_done),
        .acc_clr     (acc_clr),
        .dout_bus    (bus),
        .busy        (busy),
        .overrun     (overrun),
        .overrun_clr (overrun_clr)
    );

    always #5 clk = ~clk;

    // Reference model: words still owed to the sink, pending clear pulse,
    // sticky overrun.
    logic [15:0] mq[$];
    bit          m_clr;
    bit          m_ovr;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [34:0] got, input logic [34:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_load(input logic [34:0] v);
        logic signed [34:0] s;
        logic signed [47:0] x;
        s = v;
        x = s;                       // arithmetic sign extension to 48 bits
        mq.push_back(x[15:0]);
        mq.push_back(x[31:16]);
        mq.push_back(x[47:32]);
    endfunction

    // Advance the model by one rising edge using the inputs applied this cycle.
    function automatic void model_step();
        bit hs;
        bit can_take;
        hs       = (mq.size() > 0) && (bus.dout_ready == 1'b1);
        can_take = (mq.size() == 0) || (hs && mq.size() == 1);
        if (hs) void'(mq.pop_front());
        m_clr = 1'b0;
        if (acc_done && can_take) begin
            model_load(acc_in);
            m_clr = 1'b1;
        end
        if (acc_done && !can_take) m_ovr = 1'b1;
        else if (overrun_clr)      m_ovr = 1'b0;
    endfunction

    task automatic compare();
        chk("valid", {34'd0, bus.dout_valid}, {34'd0, mq.size() > 0});
        chk("busy", {34'd0, busy}, {34'd0, mq.size() > 0});
        chk("acc_clr", {34'd0, acc_clr}, {34'd0, m_clr});
        chk("overrun", {34'd0, overrun}, {34'd0, m_ovr});
        if (mq.size() > 0) begin
            chk("dout", {19'd0, bus.dout}, {19'd0, mq[0]});
            chk("last", {34'd0, bus.dout_last}, {34'd0, mq.size() == 1});
        end
    endtask

    // One clock: check current outputs, clock, update model, drop strobes.
    task automatic step();
        compare();
        @(posedge clk);
        model_step();
        @(negedge clk);
        acc_done    = 1'b0;
        overrun_clr = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_dout"}, {19'd0, bus.dout}, 35'd0);
        chk({tag, "_valid"}, {34'd0, bus.dout_valid}, 35'd0);
        chk({tag, "_last"}, {34'd0, bus.dout_last}, 35'd0);
        chk({tag, "_clr"}, {34'd0, acc_clr}, 35'd0);
        chk({tag, "_busy"}, {34'd0, busy}, 35'd0);
        chk({tag, "_ovr"}, {34'd0, overrun}, 35'd0);
    endtask

    initial begin
        clr_n          = 1'b0;
        acc_in         = 35'd0;
        acc_done       = 1'b0;
        overrun_clr    = 1'b0;
        bus.dout_ready = 1'b1;
        m_clr          = 1'b0;
        m_ovr          = 1'b0;
        repeat (2) @(negedge clk);
        check_all_zero("rst");
        clr_n = 1'b1;
        step();

        // Single result, sink always ready.
        acc_in = 35'h5_ABCD1234; acc_done = 1'b1;
        step();
        chk("t1_w0", {19'd0, bus.dout}, 35'h1234);
        chk("t1_clr_on", {34'd0, acc_clr}, 35'd1);
        step();
        chk("t1_w1", {19'd0, bus.dout}, 35'hABCD);
        chk("t1_clr_off", {34'd0, acc_clr}, 35'd0);
        step();
        chk("t1_w2", {19'd0, bus.dout}, 35'hFFFD);
        chk("t1_last", {34'd0, bus.dout_last}, 35'd1);
        step();
        chk("t1_idle", {34'd0, busy}, 35'd0);

        // Sink back-pressure pattern 0,1,0,0,1,1.
        acc_in = 35'h1_00000001; acc_done = 1'b1;
        step();
        begin
            logic [5:0] pat;
            pat = 6'b110010;         // applied LSB first
            for (int i = 0; i < 6; i++) begin
                bus.dout_ready = pat[i];
                step();
            end
        end
        chk("t2_idle", {34'd0, busy}, 35'd0);
        bus.dout_ready = 1'b1;

        // Dropped strobe during BEAT1, then clear/set collision.
        acc_in = 35'h0_12345678; acc_done = 1'b1;
        step();
        step();
        acc_in = 35'h0_FFFF0000; acc_done = 1'b1;
        step();
        chk("t3_w2_kept", {19'd0, bus.dout}, 35'h0000);
        chk("t3_no_clr", {34'd0, acc_clr}, 35'd0);
        chk("t3_ovr_set", {34'd0, overrun}, 35'd1);
        repeat (3) step();
        chk("t3_ovr_sticky", {34'd0, overrun}, 35'd1);
        overrun_clr = 1'b1;
        step();
        chk("t3_ovr_clr", {34'd0, overrun}, 35'd0);
        acc_in = 35'h0_00000042; acc_done = 1'b1;
        step();
        acc_done = 1'b1; overrun_clr = 1'b1;
        step();
        chk("t3_set_wins", {34'd0, overrun}, 35'd1);
        overrun_clr = 1'b1;
        step();
        step();

        // Back-to-back capture on the BEAT2 handshake.
        acc_in = 35'h0_00000000; acc_done = 1'b1;
        step();
        step();
        step();
        acc_in = 35'h7_00020003; acc_done = 1'b1;
        step();
        chk("t4_b0", {19'd0, bus.dout}, 35'h0003);
        chk("t4_busy", {34'd0, busy}, 35'd1);
        step();
        chk("t4_b1", {19'd0, bus.dout}, 35'h0002);
        step();
        chk("t4_b2", {19'd0, bus.dout}, 35'hFFFF);
        chk("t4_ovr", {34'd0, overrun}, 35'd0);
        step();

        // Asynchronous reset in the middle of BEAT1.
        acc_in = 35'h3_87654321; acc_done = 1'b1;
        step();
        step();
        #2 clr_n = 1'b0;
        #1 check_all_zero("t5_async");
        mq.delete();
        m_clr = 1'b0;
        m_ovr = 1'b0;
        #1 clr_n = 1'b1;
        @(negedge clk);
        step();
        acc_in = 35'h2_0000BEEF; acc_done = 1'b1;
        step();
        chk("t5_restart", {19'd0, bus.dout}, 35'hBEEF);
        repeat (3) step();

        // Randomized traffic.
        for (int c = 0; c < 400; c++) begin
            bus.dout_ready = ($urandom_range(0, 3) != 0);
            acc_done       = ($urandom_range(0, 3) == 0);
            overrun_clr    = ($urandom_range(0, 7) == 0);
            acc_in         = {$urandom_range(0, 7), $urandom()};
            step();
        end
        bus.dout_ready = 1'b1;
        repeat (4) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/acc_readout.md
# acc_readout

Read-side companion to the MAC accumulator register. It captures the 35-bit accumulated result when the datapath signals completion, then pulses the accumulator's clear input so the next accumulation can start. It streams the captured value out over a 16-bit valid/ready interface as three beats, LSW first. It sits between the accumulator register and the downstream result sink (bus interface or result FIFO).

## Interface

- ACC_W, 35, accumulator result width. Only the default is supported and verified.
- WORD_W, 16, output word width. Beat count is ceil(ACC_W/WORD_W), which is 3 at the defaults.
- clk  input  1  single clock; all state updates on its rising edge.
- clr_n  input  1  reset; asynchronous, active-low. Assertion resets all state immediately; deassertion is synchronous to clk.
- acc_in  input  ACC_W  accumulator output value, two's complement; sampled only when acc_done is high.
- acc_done  input  1  one-cycle strobe: accumulation complete, acc_in valid this cycle.
- acc_clr  output  1  one-cycle pulse to the accumulator's synchronous clear.
- dout  output  WORD_W  output data word.
- dout_valid  output  1  dout holds a valid beat.
- dout_ready  input  1  sink accepts the beat.
- dout_last  output  1  the current beat is the final beat of the result.
- busy  output  1  a captured result is still being drained.
- overrun  output  1  sticky flag: an acc_done strobe was dropped.
- overrun_clr  input  1  synchronous clear of overrun.

## Operation

- States:
  - IDLE, BEAT0, BEAT1, BEAT2 (encoded as a 2-bit beat counter plus an active bit).
  - Capture register cap[34:0].
- Values while clr_n is low and after reset:
  - State is IDLE.
  - cap is 0.
  - dout is 0, dout_valid is 0, dout_last is 0.
  - acc_clr is 0, busy is 0, overrun is 0.
- Capture condition: acc_done is high and the block is accept-ready. Accept-ready means either of:
  - the state is IDLE, or
  - the state is BEAT2 and dout_valid and dout_ready are both high (back-to-back capture).
- On capture:
  - cap loads acc_in.
  - The state moves to BEAT0.
  - acc_clr is high for exactly the following cycle.
- Beat contents:
  - BEAT0: dout = cap[15:0].
  - BEAT1: dout = cap[31:16].
  - BEAT2: dout = {13{cap[34]}, cap[34:32]}, i.e. the top bits sign-extended to 16 bits.
  - dout_last is high only in BEAT2.
- State advance:
  - BEAT0 and BEAT1 advance to the next beat on dout_valid && dout_ready.
  - BEAT2 goes to IDLE on handshake, or to BEAT0 if a back-to-back capture occurs in that cycle.
- Signal relations:
  - busy is high exactly when the state is not IDLE.
  - dout_valid equals busy.
  - dout and dout_last are stable while dout_valid is high and dout_ready is low.
- acc_done while busy and not accept-ready:
  - The strobe is dropped; cap is unchanged and acc_clr is not pulsed.
  - overrun is set on the next edge.
- overrun_clr clears overrun. If a set and overrun_clr occur in the same cycle, the set wins.
- Reset during a drain aborts it:
  - State is IDLE and outputs take their reset values.
  - acc_clr is not pulsed.

## Timing

- Capture edge is T:
  - Cycle T+1: acc_clr = 1, dout_valid = 1, dout = word0.
  - Cycle T+2: acc_clr = 0.
- Throughput is one beat per cycle while dout_ready is held high, so a full result takes 3 cycles.
  - Back-to-back results need no bubble: 3 cycles per result.
- Latency from acc_done to the first beat valid is 1 cycle.
- All outputs are registered; there is no combinational path from any input to any output.

## Test plan

- Reset, then acc_in = 35'h5_ABCD1234 with a single acc_done and dout_ready held at 1:
  - Beats are 16'h1234, 16'hABCD, 16'hFFFD on consecutive cycles.
  - dout_last is high only on 16'hFFFD.
  - acc_clr pulses exactly once, in the first beat cycle.
- acc_in = 35'h1_00000001 with dout_ready toggling 0,1,0,0,1,1:
  - Beats are 16'h0001, 16'h0000, 16'h0001.
  - Each beat holds stable while dout_ready is 0.
  - busy falls the cycle after the last handshake.
- acc_done during BEAT1 with acc_in = 35'h0_FFFF0000:
  - The current result completes unchanged and no acc_clr pulse is issued for the dropped strobe.
  - overrun = 1 and stays high until overrun_clr.
  - overrun_clr asserted in the same cycle as a new drop leaves overrun = 1.
- acc_done in the cycle the BEAT2 handshake completes, with acc_in = 35'h7_00020003:
  - The next cycle shows BEAT0 = 16'h0003, with no idle cycle.
  - Subsequent beats are 16'h0002 then 16'hFFFF.
  - overrun stays 0.
- clr_n pulsed low mid-BEAT1, asynchronous to clk:
  - All outputs are 0 immediately, with no acc_clr pulse.
  - After release, the next acc_done restarts cleanly at BEAT0.
